newton_controller: RTL and testbench

NEWTON_CONTROLLER -- requirements
Module: newton_controller

---
 rtl/newton_controller.sv | 195 +++++++++++++++++++
 tb/tb_newton_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/newton_controller.sv
// Sequencer for an online Newton datapath: loads x0/b digit streams, runs ITERATIONS
// passes of DIGITS+ONLINE_DELAY cycles, then streams the result. Option: NEWTON_CTRL_DIGIT_CHECK_EN.
module newton_controller #(
  parameter int DIGITS       = 16,
  parameter int ONLINE_DELAY = 3,
  parameter int ITERATIONS   = 4
) (
  input  logic       clk,
  input  logic       asyn_reset_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_x0,
  input  logic [1:0] in_b,
  output logic [1:0] x_zero,
  output logic [1:0] b_value,
  output logic       newton_enable,
  output logic       newton_clr,
  input  logic [1:0] res_digit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_digit,
  output logic       busy,
  output logic       err
);

  localparam int RUN_LEN = DIGITS + ONLINE_DELAY;
  localparam int IW      = $clog2(DIGITS);
  localparam int KW      = $clog2(RUN_LEN);
  localparam int CW      = $clog2(ITERATIONS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, DRAIN, UNLOAD} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [KW-1:0]   k;
  logic [CW-1:0]   iter;

  logic [1:0] xbuf [DIGITS];
  logic [1:0] bbuf [DIGITS];
  logic [1:0] nbuf [DIGITS];

  // Code 11 is not a legal signed digit; it is stored as zero.
  function automatic logic [1:0] sanitize(input logic [1:0] d);
    return (d == 2'b11) ? 2'b00 : d;
  endfunction

  logic          load_beat;
  logic          capture;
  logic          run_last;
  logic [KW-1:0] k_next;
  logic [IW-1:0] idx_next;
  logic [IW-1:0] cap_idx;
  logic [CW-1:0] iter_next;
  logic [1:0]    res_clean;

  assign load_beat = (state == LOAD) && in_valid;
  assign capture   = (state == RUN) && (k >= KW'(ONLINE_DELAY));
  assign run_last  = (state == RUN) && (k == KW'(RUN_LEN - 1));
  assign k_next    = k + KW'(1);
  assign idx_next  = idx + IW'(1);
  assign cap_idx   = IW'(k - KW'(ONLINE_DELAY));
  assign iter_next = iter + CW'(1);
  assign res_clean = sanitize(res_digit);

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      k             <= '0;
      iter          <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      newton_enable <= 1'b0;
      newton_clr    <= 1'b1;
      x_zero        <= 2'b00;
      b_value       <= 2'b00;
      out_digit     <= 2'b00;
    end else begin
      // NOTE: a default non-blocking assignment at the top of a clocked block is
      // overridden by any later one in the same edge; this makes newton_clr a one-cycle pulse.
      newton_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            idx      <= '0;
            iter     <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (idx == IW'(DIGITS - 1)) begin
              state      <= CLEAR;
              in_ready   <= 1'b0;
              newton_clr <= 1'b1;
              idx        <= '0;
            end else begin
              idx <= idx_next;
            end
          end
        end
        CLEAR: begin
          state         <= RUN;
          k             <= '0;
          newton_enable <= 1'b1;
          x_zero        <= xbuf[0];
          b_value       <= bbuf[0];
        end
        RUN: begin
          if (run_last) begin
            newton_enable <= 1'b0;
            x_zero        <= 2'b00;
            b_value       <= 2'b00;
            iter          <= iter_next;
            if (iter_next < CW'(ITERATIONS)) begin
              state      <= CLEAR;
              newton_clr <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            k <= k_next;
            // Past the last operand digit the datapath is fed zeros while it flushes.
            if (k_next < KW'(DIGITS)) begin
              x_zero  <= xbuf[IW'(k_next)];
              b_value <= bbuf[IW'(k_next)];
            end else begin
              x_zero  <= 2'b00;
              b_value <= 2'b00;
            end
          end
        end
        DRAIN: begin
          state     <= UNLOAD;
          out_valid <= 1'b1;
          out_digit <= xbuf[0];
          idx       <= '0;
        end
        UNLOAD: begin
          if (out_ready) begin
            if (idx == IW'(DIGITS - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_digit <= 2'b00;
              busy      <= 1'b0;
              idx       <= '0;
            end else begin
              idx       <= idx_next;
              out_digit <= xbuf[idx_next];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: digit buffers carry no reset; every entry is written before it is read in a job,
  // so clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (load_beat) begin
      xbuf[idx] <= sanitize(in_x0);
      bbuf[idx] <= sanitize(in_b);
    end
    if (capture) begin
      nbuf[cap_idx] <= res_clean;
    end
    // The final captured digit arrives on the same edge as the reload, so it bypasses nbuf.
    if (run_last) begin
      for (int i = 0; i < DIGITS; i++) begin
        xbuf[i] <= (i == DIGITS - 1) ? res_clean : nbuf[i];
      end
    end
  end

`ifdef NEWTON_CTRL_DIGIT_CHECK_EN
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      err <= 1'b0;
    end else if ((state == IDLE) && start) begin
      err <= 1'b0;
    end else if ((load_beat && ((in_x0 == 2'b11) || (in_b == 2'b11))) ||
                 (capture && (res_digit == 2'b11))) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_newton_controller.sv
// Directed bench for newton_controller with an echo datapath model (res = x_zero delayed 3 cycles),
// so every job must return the sanitised x0 digits that were loaded.
module tb_newton_controller;

  localparam int D   = 16;
  localparam int OD  = 3;
  localparam int IT  = 4;
  localparam int LAT = IT * (1 + D + OD) + 1;
`ifdef NEWTON_CTRL_DIGIT_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk, rst_n, start, in_valid, in_ready, newton_enable, newton_clr;
  logic       out_valid, out_ready, busy, err;
  logic [1:0] in_x0, in_b, x_zero, b_value, res_digit, out_digit;

  newton_controller #(.DIGITS(D), .ONLINE_DELAY(OD), .ITERATIONS(IT)) dut (
    .clk(clk), .asyn_reset_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_x0(in_x0), .in_b(in_b),
    .x_zero(x_zero), .b_value(b_value), .newton_enable(newton_enable), .newton_clr(newton_clr),
    .res_digit(res_digit), .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] p0, p1, p2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0 <= 2'b00; p1 <= 2'b00; p2 <= 2'b00;
    end else begin
      p0 <= x_zero; p1 <= p0; p2 <= p1;
    end
  end
  assign res_digit = p2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [1:0] xv [D];
  logic [1:0] bv [D];
  logic [1:0] xe [D];
  logic [1:0] be [D];

  function automatic logic [1:0] san(input logic [1:0] d);
    return (d == 2'b11) ? 2'b00 : d;
  endfunction

  bit mon_run = 1'b1;
  int run_len = 0;
  int clr_count = 0;
  int ov_count = 0;

  always @(negedge clk) begin
    if (rst_n && newton_clr) clr_count++;
    if (out_valid) ov_count++;
    if (newton_enable) begin
      if (mon_run) begin
        if (run_len < D) begin
          check("run_x_zero", x_zero, xe[run_len]);
          check("run_b_value", b_value, be[run_len]);
        end else begin
          check("flush_x_zero", x_zero, 2'b00);
        end
      end
      run_len++;
    end else if (run_len != 0) begin
      if (mon_run) check("run_len", run_len, D + OD);
      run_len = 0;
    end
  end

  task automatic set_pattern(input int sel);
    for (int i = 0; i < D; i++) begin
      case (sel)
        0: begin
          xv[i] = (i % 3 == 0) ? 2'b01 : (i % 3 == 1) ? 2'b10 : 2'b00;
          bv[i] = (i % 2 == 1) ? 2'b01 : 2'b10;
        end
        1: begin
          xv[i] = ((i / 2) % 2 == 1) ? 2'b10 : 2'b01;
          bv[i] = (i % 2 == 1) ? 2'b00 : 2'b01;
        end
        default: begin
          xv[i] = (i < 8) ? 2'b01 : 2'b10;
          bv[i] = 2'b10;
        end
      endcase
    end
    if (sel == 0) begin
      bv[5] = 2'b11;
      xv[7] = 2'b11;
    end
    for (int i = 0; i < D; i++) begin
      xe[i] = san(xv[i]);
      be[i] = san(bv[i]);
    end
  endtask

  task automatic load_job(input bit gap);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("in_ready_in_load", in_ready, 1'b1);
    check("err_cleared_by_start", err, 1'b0);
    clr_count = 0;
    ov_count  = 0;
    for (int i = 0; i < D; i++) begin
      in_valid = 1'b1; in_x0 = xv[i]; in_b = bv[i];
      @(negedge clk);
      if (gap && i != D - 1) begin
        in_valid = 1'b0; in_x0 = 2'b11; in_b = 2'b11;
        @(negedge clk);
      end
    end
    in_valid = 1'b0; in_x0 = 2'b00; in_b = 2'b00;
    check("in_ready_after_last_beat", in_ready, 1'b0);
  endtask

  task automatic wait_result(input logic exp_err);
    int lat;
    lat = 0;
    while (!out_valid && lat < 5000) begin
      if (lat == 40) begin
        check("in_ready_in_run", in_ready, 1'b0);
        start = 1'b1; in_valid = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      lat++;
    end
    check("latency", lat, LAT);
    check("clr_pulses", clr_count, IT);
    check("err_in_unload", err, exp_err);
  endtask

  task automatic unload(input bit hold);
    int j, n, stall;
    j = 0; n = 0; stall = 0;
    while (j < D && n < 300) begin
      if (out_valid) begin
        check("out_digit", out_digit, xe[j]);
        if (hold && j == 3 && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
          j++;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    check("unload_count", j, D);
    check("out_valid_after_unload", out_valid, 1'b0);
    check("busy_after_unload", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_x0 = 2'b00; in_b = 2'b00; out_ready = 1'b0;
    set_pattern(0);
    #12;
    check("rst_newton_clr", newton_clr, 1'b1);
    check("rst_outputs", {in_ready, out_valid, busy, err, newton_enable, x_zero, b_value, out_digit}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("clr_after_release", newton_clr, 1'b0);
    check("busy_idle", busy, 1'b0);

    // Back-to-back load, illegal codes on beat 5 (b) and 7 (x0), stalled unload.
    load_job(1'b0);
    wait_result(ERR_EN);
    unload(1'b1);
    check("err_persists_idle", err, ERR_EN);

    // Every-other-cycle load with garbage on idle cycles.
    set_pattern(1);
    load_job(1'b1);
    wait_result(1'b0);
    unload(1'b0);

    // Reset during RUN of the second iteration.
    set_pattern(2);
    load_job(1'b0);
    n = 0;
    while (!(clr_count == 2 && newton_enable) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_iter2_run", n < 500, 1'b1);
    repeat (5) @(negedge clk);
    mon_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_newton_clr", newton_clr, 1'b1);
    check("midrst_outputs", {in_ready, out_valid, busy, err, newton_enable, x_zero, b_value, out_digit}, '0);
    check("midrst_no_out_valid", ov_count, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_idle", busy, 1'b0);
    mon_run = 1'b1;
    load_job(1'b0);
    wait_result(1'b0);
    unload(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
